// File: rtl/eth_pkg.sv
// Shared types for the Ethernet TX path: arbiter FSM states, source identifiers, standard IFG length.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT_ARP,
    GRANT_UDP,
    ABORT,
    DRAIN,
    GAP
  } arb_state_t;

  typedef enum logic {
    SRC_ARP,
    SRC_UDP
  } arb_src_t;

  localparam int ETH_IFG_BYTES = 12;

endpackage

// File: rtl/eth_tx_arbiter.sv
// Frame-level round-robin arbiter merging the ARP and UDP byte streams onto the single MAC TX stream,
// with inter-frame gap insertion and mid-frame stall abort.
module eth_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = ETH_IFG_BYTES,
  parameter int STALL_TIMEOUT = 256,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 sys_clk_in,
  input  logic                 sys_rst_in,
  input  logic [7:0]           arp_tdata_in,
  input  logic                 arp_tvalid_in,
  input  logic                 arp_tlast_in,
  output logic                 arp_tready_out,
  input  logic [7:0]           udp_tdata_in,
  input  logic                 udp_tvalid_in,
  input  logic                 udp_tlast_in,
  output logic                 udp_tready_out,
  output logic [7:0]           mac_tdata_out,
  output logic                 mac_tvalid_out,
  output logic                 mac_tlast_out,
  output logic                 mac_tuser_out,
  input  logic                 mac_tready_in,
  output logic                 arb_busy_out,
  output logic [CNT_WIDTH-1:0] abort_cnt_out
);

  // All streams: a byte moves on a rising edge where tvalid and tready are both 1; a source holds
  // tdata/tlast stable while tvalid=1 and tready=0.
  localparam int STALL_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
  localparam int GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(IFG_CYCLES - 1);
  localparam arb_state_t         END_STATE  = (IFG_CYCLES == 0) ? IDLE : GAP;

  arb_state_t           state_q, state_d;
  arb_src_t             last_grant_q, last_grant_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] abort_cnt_q, abort_cnt_d;

  // last_grant always names the source owning the current frame, so it also selects the drain source.
  logic cur_tvalid;
  logic cur_tlast;
  assign cur_tvalid = (last_grant_q == SRC_ARP) ? arp_tvalid_in : udp_tvalid_in;
  assign cur_tlast  = (last_grant_q == SRC_ARP) ? arp_tlast_in  : udp_tlast_in;

  always_ff @(posedge sys_clk_in) begin
    if (sys_rst_in) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_UDP;
      gap_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    abort_cnt_d  = abort_cnt_q;
    case (state_q)
      IDLE: begin
        gap_cnt_d   = '0;
        stall_cnt_d = '0;
        if (arp_tvalid_in && (!udp_tvalid_in || last_grant_q == SRC_UDP)) begin
          state_d      = GRANT_ARP;
          last_grant_d = SRC_ARP;
        end else if (udp_tvalid_in) begin
          state_d      = GRANT_UDP;
          last_grant_d = SRC_UDP;
        end
      end
      GRANT_ARP, GRANT_UDP: begin
        // Backpressure with valid data held is not a stall; only a missing source byte counts.
        if (cur_tvalid) begin
          stall_cnt_d = '0;
          if (mac_tready_in && cur_tlast) state_d = END_STATE;
        end else if (stall_cnt_q == STALL_LAST) begin
          state_d = ABORT;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      ABORT: begin
        if (mac_tready_in) begin
          state_d = DRAIN;
          if (abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (cur_tvalid && cur_tlast) state_d = END_STATE;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_tdata_out  = 8'h00;
    mac_tvalid_out = 1'b0;
    mac_tlast_out  = 1'b0;
    mac_tuser_out  = 1'b0;
    arp_tready_out = 1'b0;
    udp_tready_out = 1'b0;
    case (state_q)
      GRANT_ARP: begin
        mac_tdata_out  = arp_tdata_in;
        mac_tvalid_out = arp_tvalid_in;
        mac_tlast_out  = arp_tlast_in;
        arp_tready_out = mac_tready_in;
      end
      GRANT_UDP: begin
        mac_tdata_out  = udp_tdata_in;
        mac_tvalid_out = udp_tvalid_in;
        mac_tlast_out  = udp_tlast_in;
        udp_tready_out = mac_tready_in;
      end
      ABORT: begin
        mac_tvalid_out = 1'b1;
        mac_tlast_out  = 1'b1;
        mac_tuser_out  = 1'b1;
      end
      DRAIN: begin
        if (last_grant_q == SRC_ARP) arp_tready_out = 1'b1;
        else                         udp_tready_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign arb_busy_out  = (state_q != IDLE);
  assign abort_cnt_out = abort_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: single frames, round-robin contention, backpressure, stall abort,
// mid-frame reset, and zero-gap back-to-back frames on a second instance.
module tb_eth_tx_arbiter;
  import eth_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [7:0]  arp_tdata, udp_tdata, mac_tdata, z_tdata;
  logic        arp_tvalid, arp_tlast, udp_tvalid, udp_tlast, mac_tready;
  logic        arp_tready, udp_tready, mac_tvalid, mac_tlast, mac_tuser, busy;
  logic        z_arp_tready, z_udp_tready, z_tvalid, z_tlast, z_tuser, z_busy;
  logic [15:0] abort_cnt, z_abort_cnt;

  eth_tx_arbiter dut (
    .sys_clk_in(clk), .sys_rst_in(rst),
    .arp_tdata_in(arp_tdata), .arp_tvalid_in(arp_tvalid), .arp_tlast_in(arp_tlast),
    .arp_tready_out(arp_tready),
    .udp_tdata_in(udp_tdata), .udp_tvalid_in(udp_tvalid), .udp_tlast_in(udp_tlast),
    .udp_tready_out(udp_tready),
    .mac_tdata_out(mac_tdata), .mac_tvalid_out(mac_tvalid), .mac_tlast_out(mac_tlast),
    .mac_tuser_out(mac_tuser), .mac_tready_in(mac_tready),
    .arb_busy_out(busy), .abort_cnt_out(abort_cnt)
  );

  eth_tx_arbiter #(.IFG_CYCLES(0)) dut_nogap (
    .sys_clk_in(clk), .sys_rst_in(rst),
    .arp_tdata_in(arp_tdata), .arp_tvalid_in(arp_tvalid), .arp_tlast_in(arp_tlast),
    .arp_tready_out(z_arp_tready),
    .udp_tdata_in(udp_tdata), .udp_tvalid_in(udp_tvalid), .udp_tlast_in(udp_tlast),
    .udp_tready_out(z_udp_tready),
    .mac_tdata_out(z_tdata), .mac_tvalid_out(z_tvalid), .mac_tlast_out(z_tlast),
    .mac_tuser_out(z_tuser), .mac_tready_in(mac_tready),
    .arb_busy_out(z_busy), .abort_cnt_out(z_abort_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  logic [8:0] arp_q[$];
  logic [8:0] udp_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int beat_cyc_q[$];
  bit arp_hold = 1'b0;
  bit toggle_ready = 1'b0;
  bit mirror_chk = 1'b0;
  bit use_z = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive();
    arp_tvalid = (arp_q.size() > 0) && !arp_hold;
    {arp_tlast, arp_tdata} = arp_tvalid ? arp_q[0] : 9'h000;
    udp_tvalid = (udp_q.size() > 0);
    {udp_tlast, udp_tdata} = udp_tvalid ? udp_q[0] : 9'h000;
    mac_tready = toggle_ready ? cyc_n[0] : 1'b1;
  endtask

  task automatic sample();
    logic [7:0] o_td;
    logic o_tv, o_tl, o_tu, o_at, o_ut;
    logic [8:0] tmp;
    if (use_z) begin
      o_td = z_tdata; o_tv = z_tvalid; o_tl = z_tlast; o_tu = z_tuser;
      o_at = z_arp_tready; o_ut = z_udp_tready;
    end else begin
      o_td = mac_tdata; o_tv = mac_tvalid; o_tl = mac_tlast; o_tu = mac_tuser;
      o_at = arp_tready; o_ut = udp_tready;
    end
    if (o_tv && mac_tready) begin
      got_q.push_back({o_tu, o_tl, o_td});
      beat_cyc_q.push_back(cyc_n);
    end
    if (mirror_chk && o_tv) check("udp_rdy_mirror", {31'd0, o_ut}, {31'd0, mac_tready});
    if (arp_tvalid && o_at) tmp = arp_q.pop_front();
    if (udp_tvalid && o_ut) tmp = udp_q.pop_front();
  endtask

  task automatic cyc();
    drive();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle_cyc(input bit exp_busy, input string tag);
    drive();
    @(negedge clk);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check({tag, "_tvalid"}, {31'd0, mac_tvalid}, 32'd0);
    sample();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    if (got_q.size() < n) check({tag, "_timeout"}, got_q.size(), n);
  endtask

  task automatic load(input bit is_arp, input int len, input logic [7:0] base, input int n_exp);
    for (int i = 0; i < len; i++) begin
      if (is_arp) arp_q.push_back({i == len - 1, 8'(base + i)});
      else        udp_q.push_back({i == len - 1, 8'(base + i)});
      if (i < n_exp) exp_q.push_back({1'b0, i == len - 1, 8'(base + i)});
    end
  endtask

  // scoreboard
  task automatic check_sb(input string tag);
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    beat_cyc_q.delete();
  endtask

  task automatic do_reset();
    arp_q.delete(); udp_q.delete(); got_q.delete(); exp_q.delete(); beat_cyc_q.delete();
    rst = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int b10;
    int a0;
    do_reset();
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_last_grant", 32'(dut.last_grant_q), 32'(SRC_UDP));
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tvalid", {31'd0, mac_tvalid}, 32'd0);
    check("rst_abort_cnt", {16'd0, abort_cnt}, 32'd0);

    // 42-byte ARP frame alone, then a 12-cycle gap
    t0 = cyc_n;
    load(1'b1, 42, 8'h40, 42);
    run_until(42, 100, "arp42");
    if (beat_cyc_q.size() == 42) begin
      check("arp42_latency", beat_cyc_q[0] - t0, 1);
      check("arp42_span", beat_cyc_q[41] - beat_cyc_q[0], 41);
    end
    check_sb("arp42");
    for (int i = 0; i < 13; i++) idle_cyc(i < 12, "arp42_gap");

    // simultaneous requests from reset: ARP first, then alternation
    do_reset();
    load(1'b1, 4, 8'h10, 4);
    load(1'b0, 5, 8'h20, 5);
    load(1'b1, 3, 8'h30, 3);
    load(1'b0, 2, 8'h50, 2);
    run_until(14, 200, "rr");
    if (beat_cyc_q.size() == 14) begin
      check("rr_gap_a1_u1", beat_cyc_q[4] - beat_cyc_q[3], 14);
      check("rr_gap_u1_a2", beat_cyc_q[9] - beat_cyc_q[8], 14);
    end
    check_sb("rr");

    // UDP frame under alternating backpressure
    do_reset();
    toggle_ready = 1'b1;
    mirror_chk = 1'b1;
    load(1'b0, 16, 8'hC0, 16);
    run_until(16, 100, "bp");
    toggle_ready = 1'b0;
    mirror_chk = 1'b0;
    check_sb("bp");

    // ARP stalls after byte 10: abort beat, drain, gap
    do_reset();
    load(1'b1, 20, 8'h60, 10);
    exp_q.push_back({1'b1, 1'b1, 8'h00});
    run_until(10, 50, "stall_pre");
    b10 = (beat_cyc_q.size() > 9) ? beat_cyc_q[9] : 0;
    arp_hold = 1'b1;
    run_until(11, 400, "abort");
    a0 = (beat_cyc_q.size() > 10) ? beat_cyc_q[10] : 0;
    check("abort_delay", a0 - b10, 257);
    check("abort_cnt", {16'd0, abort_cnt}, 32'd1);
    arp_hold = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("drain_empty", arp_q.size(), 0);
    check("drain_no_beats", got_q.size(), 11);
    for (int i = 0; i < 13; i++) idle_cyc(i < 12, "abort_gap");
    check_sb("abort");

    // reset in the middle of a UDP frame
    load(1'b0, 40, 8'h80, 40);
    run_until(20, 80, "pre_rst");
    for (int i = 0; i < 20; i++)
      if (got_q.size() > 0 && exp_q.size() > 0) check("pre_rst", got_q.pop_front(), exp_q.pop_front());
    udp_q.delete();
    got_q.delete();
    exp_q.delete();
    beat_cyc_q.delete();
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_state", 32'(dut.state_q), 32'(IDLE));
    check("mrst_outs", {24'd0, mac_tdata, mac_tvalid, mac_tlast, mac_tuser, arp_tready, udp_tready, busy},
          32'd0);
    check("mrst_abort_cnt", {16'd0, abort_cnt}, 32'd0);

    // zero-gap instance: back-to-back UDP frames separated by one bubble
    use_z = 1'b1;
    do_reset();
    load(1'b0, 3, 8'hE0, 3);
    load(1'b0, 3, 8'hF0, 3);
    run_until(6, 50, "b2b");
    if (beat_cyc_q.size() == 6) begin
      check("b2b_frame1_span", beat_cyc_q[2] - beat_cyc_q[0], 2);
      check("b2b_bubble", beat_cyc_q[3] - beat_cyc_q[2], 2);
    end
    check_sb("b2b");
    use_z = 1'b0;

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
